// File: rtl/booth_seq_pkg.sv
// -----------------------------------------------------------------------------
// booth_seq_pkg
// Shared definitions for the Booth multiplier job sequencer:
//   - seq_state_e    : sequencer FSM states (IDLE, ISSUE, WAIT)
//   - DEFAULT_N      : default operand width
//   - DEFAULT_DEPTH  : default result FIFO depth
//   - ptr_width()    : FIFO pointer width for a given depth
// -----------------------------------------------------------------------------
package booth_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } seq_state_e;

  localparam int DEFAULT_N     = 4;
  localparam int DEFAULT_DEPTH = 2;

  // A one-entry FIFO still needs a 1-bit pointer.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/booth_result_fifo.sv
// -----------------------------------------------------------------------------
// booth_result_fifo
// Small result FIFO with a registered head output.
// Parameters: WIDTH (entry width), DEPTH (entries, power of two, >= 2).
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_push, i_wdata     write an entry (ignored when full)
//   i_pop               remove the head (ignored when empty)
//   o_full, o_empty     occupancy flags
//   o_head              current head entry; holds its last value when empty
// -----------------------------------------------------------------------------
module booth_result_fifo
  import booth_seq_pkg::*;
#(
  parameter int WIDTH = 2 * DEFAULT_N,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int PW = ptr_width(DEPTH);

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_head;

  logic             w_push;
  logic             w_pop;
  logic [PW-1:0]    w_rd_next;
  logic [PW:0]      w_count_next;
  logic [WIDTH-1:0] w_head_next;

  assign o_full  = (r_count == (PW + 1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_head;

  assign w_push    = i_push && !o_full;
  assign w_pop     = i_pop && !o_empty;
  assign w_rd_next = w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) w_count_next = r_count + 1'b1;
    if (!w_push && w_pop) w_count_next = r_count - 1'b1;
  end

  // Head is registered. When the entry being written becomes the next head
  // (push into an empty FIFO, or push+pop with one entry) it is forwarded
  // directly, since the array slot is only written at this same edge.
  always_comb begin
    w_head_next = r_head;
    if (w_count_next != '0) begin
      if (w_push && (r_wr_ptr == w_rd_next)) w_head_next = i_wdata;
      else                                   w_head_next = r_mem[w_rd_next];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                                  r_mem[gi] <= '0;
        else if (w_push && (r_wr_ptr == PW'(gi)))      r_mem[gi] <= i_wdata;
      end
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      r_rd_ptr <= w_rd_next;
      r_count  <= w_count_next;
      r_head   <= w_head_next;
    end
  end

endmodule

// File: rtl/booth_mul_sequencer.sv
// -----------------------------------------------------------------------------
// booth_mul_sequencer
// Issues signed operand pairs to an N-bit Booth multiplier core one job at a
// time and returns the products, in issue order, through a result FIFO.
// Optional watchdog: define BOOTH_SEQ_TIMEOUT_EN to abandon a job after
// TIMEOUT_CYCLES edges in WAIT without a qualified done.
// Parameters: N (operand width), DEPTH (FIFO depth), TIMEOUT_CYCLES.
// Ports:
//   i_clk, i_rst_n                  clock, asynchronous active-low reset
//   i_in_valid/o_in_ready           operand stream handshake
//   i_in_m, i_in_q                  multiplicand / multiplier
//   o_mul_start, o_mul_m, o_mul_q   start pulse and held operands to the core
//   i_mul_product, i_mul_done       core result and done
//   o_out_valid/i_out_ready         result stream handshake
//   o_out_product                   FIFO head
//   o_busy                          FSM not in IDLE
//   o_err_timeout                   one-cycle pulse when a job is abandoned
// -----------------------------------------------------------------------------
module booth_mul_sequencer
  import booth_seq_pkg::*;
#(
  parameter int N              = DEFAULT_N,
  parameter int DEPTH          = DEFAULT_DEPTH,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_in_valid,
  output logic           o_in_ready,
  input  logic [N-1:0]   i_in_m,
  input  logic [N-1:0]   i_in_q,
  output logic           o_mul_start,
  output logic [N-1:0]   o_mul_m,
  output logic [N-1:0]   o_mul_q,
  input  logic [2*N-1:0] i_mul_product,
  input  logic           i_mul_done,
  output logic           o_out_valid,
  input  logic           i_out_ready,
  output logic [2*N-1:0] o_out_product,
  output logic           o_busy,
  output logic           o_err_timeout
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_ISSUE = ST_ISSUE;
  localparam logic [1:0] S_WAIT  = ST_WAIT;

  logic [1:0]   r_state;
  logic [N-1:0] r_mul_m;
  logic [N-1:0] r_mul_q;
  logic         r_armed;

  logic w_fifo_full;
  logic w_fifo_empty;
  logic w_accept;
  logic w_done_q;
  logic w_timeout;

  // A FIFO slot is reserved at accept, so a finished product always fits.
  assign o_in_ready  = (r_state == S_IDLE) && !w_fifo_full;
  assign w_accept    = i_in_valid && o_in_ready;
  // done only counts once it has been seen low in this job (armed).
  assign w_done_q    = (r_state == S_WAIT) && r_armed && i_mul_done;

  assign o_mul_start = (r_state == S_ISSUE);
  assign o_mul_m     = r_mul_m;
  assign o_mul_q     = r_mul_q;
  assign o_busy      = (r_state != S_IDLE);
  assign o_out_valid = !w_fifo_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_mul_m <= '0;
      r_mul_q <= '0;
      r_armed <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mul_m <= i_in_m;
            r_mul_q <= i_in_q;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_armed <= 1'b0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (!i_mul_done) r_armed <= 1'b1;
          if (w_done_q || w_timeout) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef BOOTH_SEQ_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] r_timer;
  logic          r_err_timeout;

  // r_timer holds the number of WAIT edges already passed without done.
  assign w_timeout = (r_state == S_WAIT) && !w_done_q &&
                     (r_timer == TW'(TIMEOUT_CYCLES - 1));
  assign o_err_timeout = r_err_timeout;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_timer       <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      r_err_timeout <= w_timeout;
      if (r_state == S_ISSUE)                       r_timer <= '0;
      else if (r_state == S_WAIT && !w_timeout)     r_timer <= r_timer + 1'b1;
    end
  end
`else
  assign w_timeout     = 1'b0;
  assign o_err_timeout = 1'b0;
`endif

  booth_result_fifo #(
    .WIDTH (2 * N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_done_q),
    .i_wdata (i_mul_product),
    .i_pop   (i_out_ready),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_head  (o_out_product)
  );

endmodule

// File: tb/tb_booth_mul_sequencer.sv
module tb_booth_mul_sequencer;

`ifdef BOOTH_SEQ_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_m = '0;
  logic [3:0] in_q = '0;
  logic       mul_start;
  logic [3:0] mul_m;
  logic [3:0] mul_q;
  logic [7:0] mul_product;
  logic       mul_done;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_product;
  logic       busy;
  logic       err_timeout;

  int total = 0;
  int bad = 0;

  // Behavioural core: done rises 6 edges after the start edge and stays high
  // until the next start. A manual override lets tests drive done directly.
  logic       manual = 1'b0;
  logic       man_done = 1'b0;
  logic [7:0] man_prod = '0;
  int         core_cnt;
  logic       core_done;
  logic [7:0] core_prod;

  assign mul_done    = manual ? man_done : core_done;
  assign mul_product = manual ? man_prod : core_prod;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_cnt  <= 0;
      core_done <= 1'b0;
      core_prod <= '0;
    end else if (mul_start) begin
      core_cnt  <= 6;
      core_done <= 1'b0;
      core_prod <= {{4{mul_m[3]}}, mul_m} * {{4{mul_q[3]}}, mul_q};
    end else if (core_cnt != 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1) core_done <= 1'b1;
    end
  end

  always #5 clk = ~clk;

  booth_mul_sequencer #(.N(4), .DEPTH(2), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_in_valid    (in_valid),
    .o_in_ready    (in_ready),
    .i_in_m        (in_m),
    .i_in_q        (in_q),
    .o_mul_start   (mul_start),
    .o_mul_m       (mul_m),
    .o_mul_q       (mul_q),
    .i_mul_product (mul_product),
    .i_mul_done    (mul_done),
    .o_out_valid   (out_valid),
    .i_out_ready   (out_ready),
    .o_out_product (out_product),
    .o_busy        (busy),
    .o_err_timeout (err_timeout)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Offer a pair until accepted; returns in the ISSUE cycle.
  task automatic push_job(input logic [3:0] m, input logic [3:0] q, output bit ok);
    ok = 1'b0;
    in_m = m;
    in_q = q;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (in_ready) begin
        cyc();
        in_valid = 1'b0;
        ok = 1'b1;
        return;
      end
      cyc();
    end
    in_valid = 1'b0;
  endtask

  task automatic pop_one(output logic [7:0] p, output bit ok);
    ok = 1'b0;
    p = 'x;
    for (int i = 0; i < 200; i++) begin
      if (out_valid) begin
        p = out_product;
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        ok = 1'b1;
        return;
      end
      cyc();
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!busy) begin
        ok = 1'b1;
        return;
      end
      cyc();
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (out_product !== 8'h00) begin bad++; $display("FAIL reset_out_product: got %h want 00", out_product); end
    total++; if ({mul_m, mul_q} !== 8'h00) begin bad++; $display("FAIL reset_operands: got %h want 00", {mul_m, mul_q}); end
    total++; if (mul_start !== 1'b0) begin bad++; $display("FAIL reset_mul_start: got %b want 0", mul_start); end
    total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL reset_err_timeout: got %b want 0", err_timeout); end
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_single();
    bit ok;
    int n;
    logic [7:0] p;
    push_job(4'h3, 4'hE, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_accept: got timeout want accept"); end
    total++; if ({mul_start, busy, in_ready} !== 3'b110) begin bad++; $display("FAIL single_issue: got start/busy/ready=%b want 110", {mul_start, busy, in_ready}); end
    total++; if ({mul_m, mul_q} !== 8'h3E) begin bad++; $display("FAIL single_operands: got %h want 3e", {mul_m, mul_q}); end
    cyc();
    total++; if (mul_start !== 1'b0) begin bad++; $display("FAIL single_start_width: got %b want 0", mul_start); end
    n = 0;
    while (!mul_done && n < 100) begin
      cyc();
      n++;
      if (mul_start) begin bad++; total++; $display("FAIL single_start_again: got 1 want 0"); end
    end
    total++; if (n >= 100) begin bad++; $display("FAIL single_done_wait: got timeout want done"); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid: got %b want 0", out_valid); end
    cyc();
    total++; if ({out_valid, busy, in_ready} !== 3'b101) begin bad++; $display("FAIL single_result_flags: got valid/busy/ready=%b want 101", {out_valid, busy, in_ready}); end
    total++; if (out_product !== 8'hFA) begin bad++; $display("FAIL single_product: got %h want fa", out_product); end
    pop_one(p, ok);
    total++; if ({out_valid, out_product} !== {1'b0, 8'hFA}) begin bad++; $display("FAIL single_after_pop: got valid=%b head=%h want 0 fa", out_valid, out_product); end
  endtask

  task automatic test_stale_done();
    bit ok;
    logic [7:0] p;
    manual = 1'b1;
    man_done = 1'b1;
    man_prod = 8'h99;
    push_job(4'h8, 4'h8, ok);
    total++; if (!ok || mul_start !== 1'b1) begin bad++; $display("FAIL stale_issue: got ok=%b start=%b want 1 1", ok, mul_start); end
    cyc();
    cyc();
    man_done = 1'b0;
    total++; if ({out_valid, busy} !== 2'b01) begin bad++; $display("FAIL stale_rejected: got valid/busy=%b want 01", {out_valid, busy}); end
    cyc();
    cyc();
    man_prod = 8'h40;
    man_done = 1'b1;
    cyc();
    total++; if ({out_valid, busy, out_product} !== {2'b10, 8'h40}) begin bad++; $display("FAIL stale_push: got valid/busy=%b head=%h want 10 40", {out_valid, busy}, out_product); end
    repeat (3) cyc();
    pop_one(p, ok);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stale_single_push: got valid=%b want 0", out_valid); end
    man_done = 1'b0;
    manual = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [7:0] p;
    out_ready = 1'b0;
    push_job(4'h1, 4'h2, ok);
    push_job(4'hF, 4'h3, ok);
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_idle: got timeout want idle"); end
    total++; if ({in_ready, out_valid, out_product} !== {2'b01, 8'h02}) begin bad++; $display("FAIL bp_full: got ready/valid=%b head=%h want 01 02", {in_ready, out_valid}, out_product); end
    in_m = 4'h5;
    in_q = 4'hD;
    in_valid = 1'b1;
    repeat (3) cyc();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_no_accept: got busy=%b want 0", busy); end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    total++; if ({in_ready, out_product} !== {1'b1, 8'hFD}) begin bad++; $display("FAIL bp_release: got ready=%b head=%h want 1 fd", in_ready, out_product); end
    cyc();
    in_valid = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_third_accept: got busy=%b want 1", busy); end
    pop_one(p, ok);
    total++; if (p !== 8'hFD) begin bad++; $display("FAIL bp_order_1: got %h want fd", p); end
    pop_one(p, ok);
    total++; if (p !== 8'hF1) begin bad++; $display("FAIL bp_order_2: got %h want f1", p); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] vm [6] = '{4'h7, 4'h8, 4'h2, 4'hD, 4'h0, 4'hF};
    logic [3:0] vq [6] = '{4'h7, 4'h7, 4'hF, 4'hB, 4'h5, 4'hF};
    logic [7:0] ex [6] = '{8'h31, 8'hC8, 8'hFE, 8'h0F, 8'h00, 8'h01};
    logic [7:0] p;
    bit ok;
    int n;
    for (int i = 0; i < 6; i++) begin
      push_job(vm[i], vq[i], ok);
      cyc();
      n = 0;
      while (!(mul_done && busy) && n < 100) begin cyc(); n++; end
      total++; if (n >= 100) begin bad++; $display("FAIL b2b_done_%0d: got timeout want done", i); end
      if (i > 0) begin
        total++; if ({out_valid, out_product} !== {1'b1, ex[i-1]}) begin bad++; $display("FAIL b2b_head_%0d: got valid=%b head=%h want 1 %h", i, out_valid, out_product, ex[i-1]); end
        out_ready = 1'b1;
      end
      cyc();
      out_ready = 1'b0;
      total++; if ({out_valid, out_product} !== {1'b1, ex[i]}) begin bad++; $display("FAIL b2b_result_%0d: got valid=%b head=%h want 1 %h", i, out_valid, out_product, ex[i]); end
    end
    pop_one(p, ok);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drained: got valid=%b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_job();
    bit ok;
    int stale;
    out_ready = 1'b0;
    push_job(4'h2, 4'h3, ok);
    wait_idle(ok);
    push_job(4'h3, 4'h3, ok);
    repeat (3) cyc();
    total++; if ({busy, out_valid} !== 2'b11) begin bad++; $display("FAIL rst_pre: got busy/valid=%b want 11", {busy, out_valid}); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if ({busy, out_valid, mul_start, in_ready} !== 4'b0001) begin bad++; $display("FAIL rst_async_flags: got busy/valid/start/ready=%b want 0001", {busy, out_valid, mul_start, in_ready}); end
    total++; if ({mul_m, mul_q, out_product} !== 16'h0000) begin bad++; $display("FAIL rst_async_data: got %h want 0000", {mul_m, mul_q, out_product}); end
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 15; i++) begin
      cyc();
      if (out_valid || busy) stale++;
    end
    total++; if (stale != 0 || in_ready !== 1'b1) begin bad++; $display("FAIL rst_after: got stale=%0d ready=%b want 0 1", stale, in_ready); end
  endtask

`ifdef BOOTH_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    manual = 1'b1;
    man_done = 1'b0;
    push_job(4'h1, 4'h1, ok);
    cyc();
    for (int k = 1; k <= 8; k++) begin
      cyc();
      if (k < 8) begin
        total++; if ({err_timeout, busy} !== 2'b01) begin bad++; $display("FAIL timeout_early_%0d: got err/busy=%b want 01", k, {err_timeout, busy}); end
      end
    end
    total++; if ({err_timeout, busy, out_valid} !== 3'b100) begin bad++; $display("FAIL timeout_pulse: got err/busy/valid=%b want 100", {err_timeout, busy, out_valid}); end
    cyc();
    total++; if ({err_timeout, out_valid, in_ready} !== 3'b001) begin bad++; $display("FAIL timeout_after: got err/valid/ready=%b want 001", {err_timeout, out_valid, in_ready}); end
    manual = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_stale_done();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_job();
`ifdef BOOTH_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
